// File: rtl/net_delay_emulator.sv
//==============================================================================
// Module      : net_delay_emulator
// Description : Bidirectional network delay emulator between two NIC ports.
//               Optional statistics are built when NET_EMU_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module net_delay_dir #(
    parameter int PKT_W = 512,
    parameter int DEPTH = 64,
    parameter int LAT_W = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [LAT_W+1:0]          ts_i,
    input  logic [LAT_W-1:0]          cfg_latency_i,
    input  logic [PKT_W-1:0]          tx_data_i,
    input  logic                      tx_valid_i,
    output logic [PKT_W-1:0]          rx_data_o,
    output logic                      rx_valid_o,
    output logic [15:0]               drop_cnt_o,
    output logic [31:0]               fwd_cnt_o,
    output logic [$clog2(DEPTH):0]    hiwater_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TS_W = LAT_W + 2;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [LAT_W-1:0] MIN_LAT  = LAT_W'(2);

    logic [PKT_W-1:0] data_mem [DEPTH];
    logic [TS_W-1:0]  due_mem  [DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [PKT_W-1:0] rx_data_q;
    logic             rx_valid_q;
    logic [15:0]      drop_cnt_q;

    logic             w_full, w_push, w_pop;
    logic [LAT_W-1:0] w_lat;
    logic [TS_W-1:0]  w_due_new, w_slack;

    always_comb begin
        w_full    = (count_q == FULL_CNT);
        w_push    = tx_valid_i && !w_full;
        w_lat     = (cfg_latency_i < MIN_LAT) ? MIN_LAT : cfg_latency_i;
        w_due_new = ts_i + TS_W'(w_lat);
        // Head is due once (ts - due) is non-negative in modular arithmetic
        w_slack   = ts_i - due_mem[rd_ptr_q];
        w_pop     = (count_q != '0) && !w_slack[TS_W-1];
        count_d   = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            data_mem[wr_ptr_q] <= tx_data_i;
            due_mem[wr_ptr_q]  <= w_due_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            rx_valid_q <= w_pop;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rx_data_q <= data_mem[rd_ptr_q];
            end
            if (tx_valid_i && w_full && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign drop_cnt_o = drop_cnt_q;

`ifdef NET_EMU_STATS_EN
    logic [31:0]   fwd_cnt_q;
    logic [CW-1:0] hiwater_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_cnt_q <= '0;
            hiwater_q <= '0;
        end else begin
            if (w_pop) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
            if (count_d > hiwater_q) begin
                hiwater_q <= count_d;
            end
        end
    end

    assign fwd_cnt_o = fwd_cnt_q;
    assign hiwater_o = hiwater_q;
`else
    assign fwd_cnt_o = '0;
    assign hiwater_o = '0;
`endif

endmodule

module net_delay_emulator #(
    parameter int PKT_W = 512,
    parameter int DEPTH = 64,
    parameter int LAT_W = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [LAT_W-1:0]          cfg_latency,
    input  logic [PKT_W-1:0]          a_tx_data,
    input  logic                      a_tx_valid,
    input  logic [PKT_W-1:0]          b_tx_data,
    input  logic                      b_tx_valid,
    output logic [PKT_W-1:0]          a_rx_data,
    output logic                      a_rx_valid,
    output logic [PKT_W-1:0]          b_rx_data,
    output logic                      b_rx_valid,
    output logic [15:0]               ab_drop_cnt,
    output logic [15:0]               ba_drop_cnt,
    output logic [31:0]               ab_fwd_cnt,
    output logic [31:0]               ba_fwd_cnt,
    output logic [$clog2(DEPTH):0]    ab_hiwater,
    output logic [$clog2(DEPTH):0]    ba_hiwater
);
    localparam int TS_W = LAT_W + 2;

    // Shared timestamp; two extra bits keep the wrap-safe compare unambiguous
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    net_delay_dir #(.PKT_W(PKT_W), .DEPTH(DEPTH), .LAT_W(LAT_W)) u_ab (
        .clk           (clk),
        .reset_n       (reset_n),
        .ts_i          (ts_q),
        .cfg_latency_i (cfg_latency),
        .tx_data_i     (a_tx_data),
        .tx_valid_i    (a_tx_valid),
        .rx_data_o     (b_rx_data),
        .rx_valid_o    (b_rx_valid),
        .drop_cnt_o    (ab_drop_cnt),
        .fwd_cnt_o     (ab_fwd_cnt),
        .hiwater_o     (ab_hiwater)
    );

    net_delay_dir #(.PKT_W(PKT_W), .DEPTH(DEPTH), .LAT_W(LAT_W)) u_ba (
        .clk           (clk),
        .reset_n       (reset_n),
        .ts_i          (ts_q),
        .cfg_latency_i (cfg_latency),
        .tx_data_i     (b_tx_data),
        .tx_valid_i    (b_tx_valid),
        .rx_data_o     (a_rx_data),
        .rx_valid_o    (a_rx_valid),
        .drop_cnt_o    (ba_drop_cnt),
        .fwd_cnt_o     (ba_fwd_cnt),
        .hiwater_o     (ba_hiwater)
    );

endmodule

`default_nettype wire

// File: tb/tb_net_delay_emulator.sv
//==============================================================================
// Module      : tb_net_delay_emulator
// Description : Directed self-checking bench for net_delay_emulator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_net_delay_emulator;
    localparam int PKT_W = 512;
    localparam int DEPTH = 64;
    localparam int LAT_W = 10;
    localparam int HW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic [LAT_W-1:0] cfg_latency;
    logic [PKT_W-1:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic             a_tx_valid, b_tx_valid, a_rx_valid, b_rx_valid;
    logic [15:0]      ab_drop_cnt, ba_drop_cnt;
    logic [31:0]      ab_fwd_cnt, ba_fwd_cnt;
    logic [HW-1:0]    ab_hiwater, ba_hiwater;

    net_delay_emulator #(.PKT_W(PKT_W), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_latency (cfg_latency),
        .a_tx_data   (a_tx_data),
        .a_tx_valid  (a_tx_valid),
        .b_tx_data   (b_tx_data),
        .b_tx_valid  (b_tx_valid),
        .a_rx_data   (a_rx_data),
        .a_rx_valid  (a_rx_valid),
        .b_rx_data   (b_rx_data),
        .b_rx_valid  (b_rx_valid),
        .ab_drop_cnt (ab_drop_cnt),
        .ba_drop_cnt (ba_drop_cnt),
        .ab_fwd_cnt  (ab_fwd_cnt),
        .ba_fwd_cnt  (ba_fwd_cnt),
        .ab_hiwater  (ab_hiwater),
        .ba_hiwater  (ba_hiwater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PKT_W-1:0] data;
        int               edge_n;
    } rec_t;

    rec_t exp_ab[$], exp_ba[$], obs_ab[$], obs_ba[$];
    int   last_ab = 0;
    int   last_ba = 0;
    int   ecnt    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Record every rx strobe with the number of the edge that raised it
    always @(negedge clk) begin
        if (b_rx_valid) obs_ab.push_back('{b_rx_data, ecnt});
        if (a_rx_valid) obs_ba.push_back('{a_rx_data, ecnt});
    end

    task automatic check_eq(input string tag, input logic [PKT_W-1:0] obs,
                            input logic [PKT_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int deff();
        return (cfg_latency < 2) ? 2 : int'(cfg_latency);
    endfunction

    function automatic logic [PKT_W-1:0] pat(input int s);
        return {16{32'(s) ^ 32'h3C00_0000}};
    endfunction

    // Drive one tx cycle; accepted packets are due at accept edge + D, but never
    // before the packet accepted ahead of them in the same direction.
    task automatic send(input bit va, input logic [PKT_W-1:0] da, input bit oka,
                        input bit vb, input logic [PKT_W-1:0] db, input bit okb);
        int d, e;
        a_tx_valid = va; a_tx_data = da;
        b_tx_valid = vb; b_tx_data = db;
        d = deff();
        @(negedge clk);
        if (va && oka) begin
            e = (ecnt + d > last_ab + 1) ? ecnt + d : last_ab + 1;
            exp_ab.push_back('{da, e});
            last_ab = e;
        end
        if (vb && okb) begin
            e = (ecnt + d > last_ba + 1) ? ecnt + d : last_ba + 1;
            exp_ba.push_back('{db, e});
            last_ba = e;
        end
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_dir(input string tag, input bit ba);
        rec_t eq[$], oq[$];
        if (ba) begin
            eq = exp_ba; oq = obs_ba; exp_ba.delete(); obs_ba.delete();
        end else begin
            eq = exp_ab; oq = obs_ab; exp_ab.delete(); obs_ab.delete();
        end
        check_eq({tag, " count"}, PKT_W'(oq.size()), PKT_W'(eq.size()));
        for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
            check_eq($sformatf("%s data[%0d]", tag, i), oq[i].data, eq[i].data);
            check_eq($sformatf("%s edge[%0d]", tag, i), PKT_W'(oq[i].edge_n), PKT_W'(eq[i].edge_n));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, " a_rx_valid"}, PKT_W'(a_rx_valid), '0);
        check_eq({tag, " b_rx_valid"}, PKT_W'(b_rx_valid), '0);
        check_eq({tag, " b_rx_data"}, b_rx_data, '0);
        check_eq({tag, " ab_drop"}, PKT_W'(ab_drop_cnt), '0);
        check_eq({tag, " ba_drop"}, PKT_W'(ba_drop_cnt), '0);
        check_eq({tag, " ab_fwd"}, PKT_W'(ab_fwd_cnt), '0);
        check_eq({tag, " ab_hiwater"}, PKT_W'(ab_hiwater), '0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        exp_ab.delete(); exp_ba.delete(); obs_ab.delete(); obs_ba.delete();
        last_ab = 0; last_ba = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; cfg_latency = 10;
        a_tx_valid = 1'b0; b_tx_valid = 1'b0; a_tx_data = '0; b_tx_data = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;

        // Single packet A->B at latency 10
        cfg_latency = 10;
        idle(5);
        send(1'b1, PKT_W'(8'hA5), 1'b1, 1'b0, '0, 1'b0);
        idle(20);
        compare_dir("t1 ab", 1'b0);
        compare_dir("t1 ba", 1'b1);

        // Latency 0 acts as 2; back-to-back in both directions
        cfg_latency = 0;
        for (int i = 0; i < 4; i++) send(1'b1, pat(16 + i), 1'b1, 1'b1, pat(32 + i), 1'b1);
        idle(10);
        compare_dir("t2 ab", 1'b0);
        compare_dir("t2 ba", 1'b1);

        // Overflow: 70 packets into a 64-deep FIFO
        cfg_latency = 1023;
        for (int i = 0; i < 70; i++) send(1'b1, pat(100 + i), (i < 64), 1'b0, '0, 1'b0);
        check_eq("t3 ab_drop", PKT_W'(ab_drop_cnt), PKT_W'(6));
        check_eq("t3 ba_drop", PKT_W'(ba_drop_cnt), PKT_W'(0));
        idle(1033);
        compare_dir("t3 ab", 1'b0);
        compare_dir("t3 ba", 1'b1);

        // Latency decrease while entries are queued
        cfg_latency = 200;
        for (int i = 0; i < 20; i++) send(1'b1, pat(200 + i), 1'b1, 1'b0, '0, 1'b0);
        cfg_latency = 5;
        for (int i = 0; i < 3; i++) send(1'b1, pat(300 + i), 1'b1, 1'b0, '0, 1'b0);
        idle(240);
        send(1'b1, pat(400), 1'b1, 1'b0, '0, 1'b0);
        idle(15);
        compare_dir("t4 ab", 1'b0);

        // Reset with packets buffered
        cfg_latency = 50;
        for (int i = 0; i < 8; i++) send(1'b1, pat(500 + i), 1'b1, 1'b0, '0, 1'b0);
        do_reset("t5 reset");
        idle(80);
        compare_dir("t5 flushed", 1'b0);
        send(1'b1, pat(600), 1'b1, 1'b0, '0, 1'b0);
        idle(60);
        compare_dir("t5 ab", 1'b0);

        // Statistics run
        do_reset("t6 reset");
        cfg_latency = 4;
        for (int i = 0; i < 300; i++) send(1'b1, pat(1000 + i), 1'b1, 1'b0, '0, 1'b0);
        idle(10);
        compare_dir("t6 ab", 1'b0);
`ifdef NET_EMU_STATS_EN
        check_eq("t6 ab_fwd", PKT_W'(ab_fwd_cnt), PKT_W'(300));
        check_eq("t6 ab_hiwater", PKT_W'(ab_hiwater), PKT_W'(4));
`else
        check_eq("t6 ab_fwd", PKT_W'(ab_fwd_cnt), PKT_W'(0));
        check_eq("t6 ab_hiwater", PKT_W'(ab_hiwater), PKT_W'(0));
`endif
        check_eq("t6 ba_fwd", PKT_W'(ba_fwd_cnt), PKT_W'(0));
        check_eq("t6 ba_hiwater", PKT_W'(ba_hiwater), PKT_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
